// File: rtl/bit_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : bit_counter_param
//  Summary  : Start/done population counter over a DATA_W-bit word. It counts
//             ones, or zeros when count_zeros is set. Each cycle it shifts the
//             captured word right and adds the bit shifted out. It stops early
//             as soon as the shift register is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_counter_param #(
    parameter int DATA_W = 10,
    parameter int RES_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              count_zeros,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              a_eq_zero,
    output logic [RES_W-1:0]  result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [RES_W-1:0]    r_result;
    logic                r_busy;
    logic                r_done;
    logic                w_a_eq_zero;

    assign w_a_eq_zero = (r_a == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= count_zeros ? ~data_in : data_in;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // Early exit: once no set bits remain, the count is final.
                    if (w_a_eq_zero) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_a      <= r_a >> 1;
                        r_result <= r_result + RES_W'(r_a[0]);
                    end
                end
                S_DONE: begin
                    // Hold until the requester drops start (full handshake).
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign a_eq_zero = w_a_eq_zero;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_bit_counter_param.sv
`default_nettype none
// Testbench for bit_counter_param: directed cases plus random words,
// checked against a popcount/latency model derived from the word itself.
module tb_bit_counter_param;

    localparam int DATA_W = 10;
    localparam int RES_W  = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              count_zeros;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              a_eq_zero;
    logic [RES_W-1:0]  result;

    int vectors    = 0;
    int miscompares = 0;

    bit_counter_param #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .count_zeros (count_zeros),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .a_eq_zero   (a_eq_zero),
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: ones in the effective word, and its highest-set-bit span.
    function automatic int model_count(input logic [DATA_W-1:0] d, input logic mode);
        logic [DATA_W-1:0] w;
        int n;
        w = mode ? ~d : d;
        n = 0;
        for (int i = 0; i < DATA_W; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic int model_span(input logic [DATA_W-1:0] d, input logic mode);
        logic [DATA_W-1:0] w;
        int k;
        w = mode ? ~d : d;
        k = 0;
        for (int i = 0; i < DATA_W; i++) if (w[i]) k = i + 1;
        return k;
    endfunction

    // Issue one request from IDLE, check latency, busy span and result,
    // optionally holding start through DONE for 5 cycles.
    task automatic run_count(input string tag, input logic [DATA_W-1:0] d,
                             input logic mode, input bit hold);
        int exp_cnt, k, n, busy_cycles;
        bit got;
        exp_cnt = model_count(d, mode);
        k       = model_span(d, mode);
        data_in = d;
        count_zeros = mode;
        start   = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        busy_cycles = int'(busy);
        n   = 0;
        got = 1'b0;
        for (int i = 1; i <= DATA_W + 4 && !got; i++) begin
            data_in     = DATA_W'($urandom);
            count_zeros = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                n   = i;
            end else begin
                busy_cycles += int'(busy);
            end
        end
        chk({tag, "_latency"}, n, k + 1);
        chk({tag, "_busy_cycles"}, busy_cycles, k + 1);
        chk({tag, "_result"}, 32'(result), exp_cnt);
        chk({tag, "_busy_in_done"}, 32'(busy), 0);
        chk({tag, "_a_eq_zero"}, 32'(a_eq_zero), 1);
        if (hold) begin
            for (int j = 0; j < 5; j++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_done"}, 32'(done), 1);
                chk({tag, "_hold_result"}, 32'(result), exp_cnt);
            end
            start = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_idle_done"}, 32'(done), 0);
        chk({tag, "_idle_result"}, 32'(result), exp_cnt);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        count_zeros = 1'b0;
        data_in     = '0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_a_eq_zero", 32'(a_eq_zero), 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        run_count("t1_ones3", 10'b0000010101, 1'b0, 1'b0);
        run_count("t2_zero_word", 10'b0000000000, 1'b0, 1'b0);
        run_count("t2_all_ones_zeros", 10'b1111111111, 1'b1, 1'b0);
        run_count("t3_msb_only", 10'b1000000000, 1'b0, 1'b0);
        run_count("t3_all_ones", 10'b1111111111, 1'b0, 1'b0);
        run_count("t4_zeros4", 10'b1111110000, 1'b1, 1'b0);
        run_count("t5_hold", 10'b0101010101, 1'b0, 1'b1);
        run_count("t5_restart", 10'b0000000011, 1'b0, 1'b0);

        // Asynchronous abort three cycles into a worst-case count.
        data_in     = 10'b1000000000;
        count_zeros = 1'b0;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_abort_busy", 32'(busy), 0);
        chk("t6_abort_done", 32'(done), 0);
        chk("t6_abort_result", 32'(result), 0);
        chk("t6_abort_a_eq_zero", 32'(a_eq_zero), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        run_count("t6_fresh", 10'b1011001110, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            run_count("rand", DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
